cmult_arbiter: RTL
==================

CMULT_ARBITER -- requirements
Module: cmult_arbiter

Interface
REQ-001 SHALL have parameter INTEGER_SIZE, default 8, integer bits of each operand.
REQ-002 SHALL have parameter FRACT_SIZE, default 8, fractional bits of each operand; DW = INTEGER_SIZE+FRACT_SIZE.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from the complex multiplier's operand input to its result output.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid0/req_valid1, input, 1 each, requester 0/1 holds an operand pair.
REQ-007 SHALL have ports req_ready0/req_ready1, output, 1 each, grant to requester 0/1 this cycle.
REQ-008 SHALL have ports a0_r,a0_i,b0_r,b0_i and a1_r,a1_i,b1_r,b1_i, input, DW signed each, operands of requesters 0/1.
REQ-009 SHALL have ports mul_in1_r,mul_in1_i,mul_in2_r,mul_in2_i, output, DW signed each, operands driven to the shared complex multiplier.
REQ-010 SHALL have ports mul_out_r,mul_out_i, input, DW signed each, multiplier result.
REQ-011 SHALL have ports rsp_r,rsp_i, output, DW signed each, result returned to requesters.
REQ-012 SHALL have ports rsp_valid0/rsp_valid1, output, 1 each, rsp_r/rsp_i belong to requester 0/1.
REQ-013 SHALL have port flush, input, 1, request to stop granting and drain the pipeline.
REQ-014 SHALL have port flush_done, output, 1, one-cycle pulse when the drain completes.
REQ-015 SHALL have port busy, output, 1, high while any tag-pipeline stage is valid.

Function
REQ-016 SHALL implement FSM states ARB, DRAIN, DONE; grants are issued only in ARB.
REQ-017 SHALL, in ARB with flush=0, grant at most one requester per cycle: a single valid requester is granted; if both are valid, the one selected by the priority pointer is granted.
REQ-018 SHALL, after a cycle in which both requesters were valid and one was granted, set the priority pointer to the other requester; otherwise the pointer holds.
REQ-019 SHALL drive req_readyN combinationally, with req_readyN=1 only when requester N is granted; a transfer occurs when req_validN and req_readyN are both high.
REQ-020 SHALL drive mul_in1=aN and mul_in2=bN of the granted requester in the grant cycle, and all-zero operands when no grant is issued.
REQ-021 SHALL shift a LATENCY-deep tag pipeline of {valid, id} every cycle, loading {1, granted id} or {0, x} at its input.
REQ-022 SHALL assert rsp_validN exactly LATENCY cycles after a requester-N transfer, for one cycle per transfer; rsp_r/rsp_i SHALL equal mul_out_r/mul_out_i combinationally.
REQ-023 SHALL sustain one transfer per cycle with back-to-back grants and no bubbles.
REQ-024 SHALL, in ARB with flush=1, issue no grant in that cycle and move to DRAIN; flush is ignored in DRAIN and DONE.
REQ-025 SHALL stay in DRAIN until all tag stages are invalid, then move to DONE; it SHALL move from DRAIN to DONE after one cycle if the pipeline is already empty.
REQ-026 SHALL assert flush_done for one cycle in DONE and return to ARB unconditionally.
REQ-027 SHALL keep rsp_valid outputs active during DRAIN so in-flight results are still delivered.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set the state to ARB, the priority pointer to requester 0, and all tag valid bits to 0.
REQ-029 SHALL, while rst=1, hold req_ready0/1, rsp_valid0/1, flush_done and busy at 0, and mul_in1/mul_in2 at 0.
REQ-030 SHALL discard any in-flight results when reset occurs mid-operation; no rsp_valid pulse follows reset for a pre-reset transfer.

Verification
REQ-031 SHALL verify a single requester: valid0 with a0=(0x0200,0x0100), b0=(0x0100,0x0000) in Q8.8, and the multiplier model -> ready0 in the same cycle, rsp_valid0 two cycles later with rsp=(0x0200,0x0100).
REQ-032 SHALL verify contention: both valid for 4 cycles after reset -> grants in the order 0,1,0,1, and rsp_valid alternating 0,1,0,1 from cycle +2.
REQ-033 SHALL verify flush with 2 transfers in flight: flush=1 -> no grant, busy=1 for 2 cycles, both rsp_valid pulses seen, flush_done pulse, then ARB grants resume.
REQ-034 SHALL verify flush on an empty pipeline: flush=1 in ARB -> DRAIN for 1 cycle, flush_done on the following cycle.
REQ-035 SHALL verify reset mid-stream: rst=1 for 1 cycle, one cycle after a grant -> no rsp_valid for that transfer, and the pointer returns to requester 0.
REQ-036 SHALL verify no stray outputs: both valid inputs low for 10 cycles -> mul_in all zero, rsp_valid0/1 and busy stay 0.

Source files
------------

// File: rtl/cmult_arbiter.sv
// rtl/cmult_arbiter.sv - two-requester arbiter in front of a shared pipelined complex multiplier
module cmult_arbiter #(
    parameter int INTEGER_SIZE = 8,
    parameter int FRACT_SIZE   = 8,
    parameter int LATENCY      = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        req_valid0,
    input  logic                                        req_valid1,
    output logic                                        req_ready0,
    output logic                                        req_ready1,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   a0_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   a0_i,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   b0_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   b0_i,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   a1_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   a1_i,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   b1_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   b1_i,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_in1_r,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_in1_i,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_in2_r,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_in2_i,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_out_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   mul_out_i,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   rsp_r,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]   rsp_i,
    output logic                                        rsp_valid0,
    output logic                                        rsp_valid1,
    input  logic                                        flush,
    output logic                                        flush_done,
    output logic                                        busy
);

    localparam int DW = INTEGER_SIZE + FRACT_SIZE;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 ptr_q;
    logic                 ptr_d;
    logic                 grant0;
    logic                 grant1;
    logic                 done_pulse;
    logic [LATENCY-1:0]   tag_valid;
    logic [LATENCY-1:0]   tag_id;

    always_comb begin
        state_d    = state_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            ARB: begin
                if (flush) begin
                    state_d = DRAIN;
                end else begin
                    // ptr_q names the requester that wins a tie
                    grant0 = req_valid0 && (!req_valid1 || !ptr_q);
                    grant1 = req_valid1 && (!req_valid0 ||  ptr_q);
                end
            end
            DRAIN: begin
                if (tag_valid == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                state_d    = ARB;
            end
            default: state_d = ARB;
        endcase
        if (rst) begin
            grant0     = 1'b0;
            grant1     = 1'b0;
            done_pulse = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (req_valid0 && req_valid1 && (grant0 || grant1)) begin
            ptr_d = grant0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= 1'b0;
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int k = LATENCY - 1; k > 0; k--) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
            tag_valid[0] <= grant0 || grant1;
            tag_id[0]    <= grant1;
        end
    end

    always_comb begin
        mul_in1_r = '0;
        mul_in1_i = '0;
        mul_in2_r = '0;
        mul_in2_i = '0;
        if (grant0) begin
            mul_in1_r = a0_r;
            mul_in1_i = a0_i;
            mul_in2_r = b0_r;
            mul_in2_i = b0_i;
        end else if (grant1) begin
            mul_in1_r = a1_r;
            mul_in1_i = a1_i;
            mul_in2_r = b1_r;
            mul_in2_i = b1_i;
        end
    end

    assign req_ready0 = grant0;
    assign req_ready1 = grant1;
    assign flush_done = done_pulse;

    // The last tag stage lines up with the multiplier output of the same transfer
    assign rsp_valid0 = !rst && tag_valid[LATENCY-1] && !tag_id[LATENCY-1];
    assign rsp_valid1 = !rst && tag_valid[LATENCY-1] &&  tag_id[LATENCY-1];
    assign rsp_r      = mul_out_r;
    assign rsp_i      = mul_out_i;
    assign busy       = !rst && (tag_valid != '0);

endmodule
